gpu_op_dispatcher: RTL and testbench

- Sits between the GPU op queue (its dequeue side) and the GPU execution resources.
- Pops one op at a time and decodes it. Routes memory ops to the memory port and all other ops to the compute port, each with a valid/ready handshake.
- Enforces per-unit outstanding-op credits, a 16-entry destination-register scoreboard (WAW/RAW on dest), and a store fence (writes wait for all prior memory ops).

---
 rtl/gpu_dispatch_pkg.sv | 45 ++++
 rtl/gpu_op_dispatcher_if.sv | 39 +++
 rtl/gpu_reg_scoreboard.sv | 37 +++
 rtl/gpu_op_dispatcher.sv | 168 ++++++++++++++++
 tb/tb_gpu_op_dispatcher.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpu_dispatch_pkg.sv
// Shared types and instruction field layout for the GPU op dispatcher.
// The instruction layout is fixed; INSTR_W/ADDR_W are the widths the packed op struct assumes.
package gpu_dispatch_pkg;

   localparam int unsigned INSTR_W  = 80;
   localparam int unsigned ADDR_W   = 32;
   localparam int unsigned NUM_REGS = 16;

   localparam int unsigned BIT_VECTOR    = 0;
   localparam int unsigned BIT_WRITE_MEM = 1;
   localparam int unsigned BIT_READ_MEM  = 2;
   localparam int unsigned BIT_MULTI     = 3;
   localparam int unsigned OPCODE_LSB    = 4;
   localparam int unsigned OPCODE_MSB    = 11;
   localparam int unsigned DEST_LSB      = 12;
   localparam int unsigned DEST_MSB      = 15;
   localparam int unsigned DATA_LSB      = 16;
   localparam int unsigned DATA_MSB      = 79;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StDrain
   } state_e;

   typedef enum logic {
      PortExec,
      PortMem
   } port_e;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  src;
      logic [ADDR_W-1:0]  dst;
   } op_t;

   function automatic logic [3:0] op_dest(input logic [INSTR_W-1:0] instr);
      return instr[DEST_MSB:DEST_LSB];
   endfunction

   function automatic port_e op_port(input logic [INSTR_W-1:0] instr);
      return (instr[BIT_WRITE_MEM] || instr[BIT_READ_MEM]) ? PortMem : PortExec;
   endfunction

endpackage

// File: rtl/gpu_op_dispatcher_if.sv
// Queue, issue and completion signals between the dispatcher (master) and its
// surroundings (slave: op queue, compute unit, memory unit).
interface gpu_op_dispatcher_if #(
   parameter int unsigned INSTR_WIDTH = 80,
   parameter int unsigned ADDR_WIDTH  = 32
) ();

   logic                   o_dequeue_req;
   logic                   i_dequeue_valid;
   logic [INSTR_WIDTH-1:0] i_instruction;
   logic [ADDR_WIDTH-1:0]  i_src_addr;
   logic [ADDR_WIDTH-1:0]  i_dst_addr;

   logic                   o_exec_valid;
   logic                   i_exec_ready;
   logic                   o_mem_valid;
   logic                   i_mem_ready;
   logic [INSTR_WIDTH-1:0] o_op_instr;
   logic [ADDR_WIDTH-1:0]  o_op_src_addr;
   logic [ADDR_WIDTH-1:0]  o_op_dst_addr;

   logic                   i_exec_done;
   logic [3:0]             i_exec_done_reg;
   logic                   i_mem_done;
   logic [3:0]             i_mem_done_reg;

   modport master (
      output o_dequeue_req, o_exec_valid, o_mem_valid, o_op_instr, o_op_src_addr, o_op_dst_addr,
      input  i_dequeue_valid, i_instruction, i_src_addr, i_dst_addr, i_exec_ready, i_mem_ready,
      input  i_exec_done, i_exec_done_reg, i_mem_done, i_mem_done_reg
   );

   modport slave (
      input  o_dequeue_req, o_exec_valid, o_mem_valid, o_op_instr, o_op_src_addr, o_op_dst_addr,
      output i_dequeue_valid, i_instruction, i_src_addr, i_dst_addr, i_exec_ready, i_mem_ready,
      output i_exec_done, i_exec_done_reg, i_mem_done, i_mem_done_reg
   );

endinterface

// File: rtl/gpu_reg_scoreboard.sv
// Destination-register busy vector: one set port, two clear ports, combinational lookup.
// A set and a clear of the same register in one cycle leaves it busy.
module gpu_reg_scoreboard
   import gpu_dispatch_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       set_valid_i,
   input  logic [3:0] set_reg_i,
   input  logic       clr_a_valid_i,
   input  logic [3:0] clr_a_reg_i,
   input  logic       clr_b_valid_i,
   input  logic [3:0] clr_b_reg_i,
   input  logic [3:0] lookup_reg_i,
   output logic       lookup_busy_o
);

   logic [NUM_REGS-1:0] busy_q, busy_d;

   always_comb begin
      busy_d = busy_q;
      if (clr_a_valid_i) busy_d[clr_a_reg_i] = 1'b0;
      if (clr_b_valid_i) busy_d[clr_b_reg_i] = 1'b0;
      if (set_valid_i)   busy_d[set_reg_i]   = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   assign lookup_busy_o = busy_q[lookup_reg_i];

endmodule

// File: rtl/gpu_op_dispatcher.sv
// Pops ops from the GPU op queue and issues them to the compute or memory port under credit,
// scoreboard and store-fence rules. Statistics counters exist only with GPU_DISPATCH_STATS_EN.
module gpu_op_dispatcher
   import gpu_dispatch_pkg::*;
#(
   parameter int unsigned INSTR_WIDTH     = INSTR_W,
   parameter int unsigned ADDR_WIDTH      = ADDR_W,
   parameter int unsigned MAX_OUTSTANDING = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_enable,
   input  logic                i_flush,
   gpu_op_dispatcher_if.master bus,
   output logic                o_busy,
   output logic                o_flush_done,
   output logic                o_err_illegal,
   output logic                o_err_underflow,
   output logic [31:0]         o_stat_exec,
   output logic [31:0]         o_stat_mem,
   output logic [31:0]         o_stat_stall
);

   localparam logic [3:0] MaxCred = 4'(MAX_OUTSTANDING);

   state_e     state_q, state_d;
   op_t        op_q, op_d;
   logic [3:0] cred_exec_q, cred_exec_d;
   logic [3:0] cred_mem_q, cred_mem_d;
   logic       err_ill_q, err_ill_d;
   logic       err_uf_q, err_uf_d;

   logic       wr_mem, illegal, dest_busy, can_issue;
   logic [3:0] dest;
   port_e      sel;
   logic [3:0] sel_cred;
   logic       acc_exec, acc_mem;
   logic       done_exec_ok, done_mem_ok;

   assign wr_mem   = op_q.instr[BIT_WRITE_MEM];
   assign illegal  = op_q.instr[BIT_WRITE_MEM] & op_q.instr[BIT_READ_MEM];
   assign dest     = op_dest(op_q.instr);
   assign sel      = op_port(op_q.instr);
   assign sel_cred = (sel == PortMem) ? cred_mem_q : cred_exec_q;

   // Every term only relaxes while an op waits, so valid is never withdrawn before ready.
   assign can_issue = (state_q == StIssue) && !illegal && (sel_cred < MaxCred) && !dest_busy &&
                      (!wr_mem || (cred_mem_q == 4'd0));

   assign bus.o_exec_valid  = can_issue && (sel == PortExec);
   assign bus.o_mem_valid   = can_issue && (sel == PortMem);
   assign bus.o_op_instr    = op_q.instr;
   assign bus.o_op_src_addr = op_q.src;
   assign bus.o_op_dst_addr = op_q.dst;

   assign acc_exec = bus.o_exec_valid && bus.i_exec_ready;
   assign acc_mem  = bus.o_mem_valid && bus.i_mem_ready;

   // A completion with no credit outstanding is ignored apart from raising the error.
   assign done_exec_ok = bus.i_exec_done && (cred_exec_q != 4'd0);
   assign done_mem_ok  = bus.i_mem_done && (cred_mem_q != 4'd0);

   gpu_reg_scoreboard u_scoreboard (
      .clk           (clk),
      .rst           (rst),
      .set_valid_i   (acc_exec || acc_mem),
      .set_reg_i     (dest),
      .clr_a_valid_i (done_exec_ok),
      .clr_a_reg_i   (bus.i_exec_done_reg),
      .clr_b_valid_i (done_mem_ok),
      .clr_b_reg_i   (bus.i_mem_done_reg),
      .lookup_reg_i  (dest),
      .lookup_busy_o (dest_busy)
   );

   always_comb begin
      state_d           = state_q;
      op_d              = op_q;
      err_ill_d         = err_ill_q;
      bus.o_dequeue_req = 1'b0;
      o_flush_done      = 1'b0;
      case (state_q)
         StIdle: begin
            if (i_flush) begin
               state_d = StDrain;
            end else if (i_enable && bus.i_dequeue_valid) begin
               bus.o_dequeue_req = 1'b1;
               op_d              = '{instr: bus.i_instruction, src: bus.i_src_addr,
                                     dst: bus.i_dst_addr};
               state_d           = StIssue;
            end
         end
         StIssue: begin
            if (illegal) err_ill_d = 1'b1;
            // Flush discards a held op unless it was accepted this very cycle.
            if (i_flush) begin
               state_d = StDrain;
            end else if (illegal || acc_exec || acc_mem) begin
               state_d = StIdle;
            end
         end
         StDrain: begin
            if ((cred_exec_q == 4'd0) && (cred_mem_q == 4'd0)) begin
               o_flush_done = 1'b1;
               state_d      = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      cred_exec_d = cred_exec_q + 4'(acc_exec) - 4'(done_exec_ok);
      cred_mem_d  = cred_mem_q + 4'(acc_mem) - 4'(done_mem_ok);
      err_uf_d    = err_uf_q | (bus.i_exec_done && (cred_exec_q == 4'd0)) |
                    (bus.i_mem_done && (cred_mem_q == 4'd0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         op_q        <= '0;
         cred_exec_q <= 4'd0;
         cred_mem_q  <= 4'd0;
         err_ill_q   <= 1'b0;
         err_uf_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         cred_exec_q <= cred_exec_d;
         cred_mem_q  <= cred_mem_d;
         err_ill_q   <= err_ill_d;
         err_uf_q    <= err_uf_d;
      end
   end

   assign o_busy          = (state_q != StIdle) || (cred_exec_q != 4'd0) || (cred_mem_q != 4'd0);
   assign o_err_illegal   = err_ill_q;
   assign o_err_underflow = err_uf_q;

`ifdef GPU_DISPATCH_STATS_EN
   logic [31:0] stat_exec_q, stat_mem_q, stat_stall_q;
   logic        stall;

   assign stall = (state_q == StIssue) && !acc_exec && !acc_mem;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_exec_q  <= '0;
         stat_mem_q   <= '0;
         stat_stall_q <= '0;
      end else begin
         stat_exec_q  <= stat_exec_q + 32'(acc_exec);
         stat_mem_q   <= stat_mem_q + 32'(acc_mem);
         stat_stall_q <= stat_stall_q + 32'(stall);
      end
   end

   assign o_stat_exec  = stat_exec_q;
   assign o_stat_mem   = stat_mem_q;
   assign o_stat_stall = stat_stall_q;
`else
   assign o_stat_exec  = '0;
   assign o_stat_mem   = '0;
   assign o_stat_stall = '0;
`endif

endmodule

// File: tb/tb_gpu_op_dispatcher.sv
// Self-checking bench for gpu_op_dispatcher: directed scenarios plus a randomized run checked
// against a transaction-level model of the dispatch rules.
module tb_gpu_op_dispatcher;
   import gpu_dispatch_pkg::*;

   localparam int unsigned MAXO = 4;

   typedef struct packed {
      logic [79:0] instr;
      logic [31:0] src;
      logic [31:0] dst;
   } op_s;

   logic        clk = 1'b0;
   logic        rst;
   logic        en, flush;
   logic        busy, fdone, eill, euf;
   logic [31:0] se, sm, ss;

   int  checks = 0;
   int  errors = 0;
   op_s pend[$];
   int  exec_hs, mem_hs, deq_cnt, fd_cnt;
   bit  last_deq, last_ev, last_mv, last_fd;

   gpu_op_dispatcher_if #(.INSTR_WIDTH(80), .ADDR_WIDTH(32)) bus ();

   gpu_op_dispatcher #(
      .INSTR_WIDTH     (80),
      .ADDR_WIDTH      (32),
      .MAX_OUTSTANDING (MAXO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .i_enable        (en),
      .i_flush         (flush),
      .bus             (bus),
      .o_busy          (busy),
      .o_flush_done    (fdone),
      .o_err_illegal   (eill),
      .o_err_underflow (euf),
      .o_stat_exec     (se),
      .o_stat_mem      (sm),
      .o_stat_stall    (ss)
   );

   always #5 clk = ~clk;

   function automatic logic [79:0] mk(input logic [3:0] low, input logic [3:0] dest);
      logic [79:0] v;
      v        = '0;
      v[3:0]   = low;
      v[11:4]  = 8'($urandom);
      v[15:12] = dest;
      v[79:16] = {$urandom, $urandom};
      return v;
   endfunction

   task automatic push(input logic [79:0] instr);
      op_s o;
      o.instr = instr;
      o.src   = $urandom;
      o.dst   = $urandom;
      pend.push_back(o);
   endtask

   task automatic clear_inputs();
      en = 0; flush = 0;
      bus.i_dequeue_valid = 0; bus.i_instruction = '0;
      bus.i_src_addr = '0; bus.i_dst_addr = '0;
      bus.i_exec_ready = 0; bus.i_mem_ready = 0;
      bus.i_exec_done = 0; bus.i_exec_done_reg = '0;
      bus.i_mem_done = 0; bus.i_mem_done_reg = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      pend.delete();
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      exec_hs = 0; mem_hs = 0; deq_cnt = 0; fd_cnt = 0;
   endtask

   // One clock: present queue head, sample outputs mid-cycle, then clear one-shot inputs.
   task automatic cycle();
      bus.i_dequeue_valid = pend.size() > 0;
      if (pend.size() > 0) begin
         bus.i_instruction = pend[0].instr;
         bus.i_src_addr    = pend[0].src;
         bus.i_dst_addr    = pend[0].dst;
      end
      #1;
      last_deq = bus.o_dequeue_req;
      last_ev  = bus.o_exec_valid;
      last_mv  = bus.o_mem_valid;
      last_fd  = fdone;
      if (last_deq) deq_cnt++;
      if (last_deq && pend.size() > 0) void'(pend.pop_front());
      if (last_ev && bus.i_exec_ready) exec_hs++;
      if (last_mv && bus.i_mem_ready) mem_hs++;
      if (last_fd) fd_cnt++;
      @(posedge clk);
      #1;
      flush = 0; bus.i_exec_done = 0; bus.i_mem_done = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1;
      #3;
      checks++;
      if ({bus.o_dequeue_req, bus.o_exec_valid, bus.o_mem_valid, busy, fdone, eill, euf} !== 7'd0)
         begin errors++; $display("FAIL reset_ctrl got %b want 0",
            {bus.o_dequeue_req, bus.o_exec_valid, bus.o_mem_valid, busy, fdone, eill, euf}); end
      checks++;
      if ({bus.o_op_instr, bus.o_op_src_addr, bus.o_op_dst_addr} !== '0)
         begin errors++; $display("FAIL reset_payload got %h want 0", bus.o_op_instr); end
      checks++;
      if ({se, sm, ss} !== 96'd0)
         begin errors++; $display("FAIL reset_stats got %h want 0", {se, sm, ss}); end
   endtask

   task automatic test_scalar_scoreboard();
      logic [79:0] first;
      do_reset();
      en = 1; bus.i_exec_ready = 1;
      push(mk(4'b0000, 4'd3));
      first = pend[0].instr;
      cycle();
      checks++;
      if (last_deq !== 1'b1) begin errors++; $display("FAIL scalar_deq got %b want 1", last_deq); end
      cycle();
      checks++;
      if (!(last_ev && !last_mv && exec_hs == 1))
         begin errors++; $display("FAIL scalar_exec_valid got ev=%b mv=%b hs=%0d want 1 0 1",
            last_ev, last_mv, exec_hs); end
      checks++;
      if (bus.o_op_instr !== first || busy !== 1'b1)
         begin errors++; $display("FAIL scalar_hold got %h busy=%b want %h busy=1",
            bus.o_op_instr, busy, first); end
      // Second op on the same dest must wait for the first to complete.
      push(mk(4'b0001, 4'd3));
      repeat (3) cycle();
      checks++;
      if (last_ev !== 1'b0 || exec_hs != 1)
         begin errors++; $display("FAIL waw_blocked got ev=%b hs=%0d want 0 1", last_ev, exec_hs); end
      bus.i_exec_done = 1; bus.i_exec_done_reg = 4'd3;
      cycle();
      checks++;
      if (last_ev !== 1'b0) begin errors++; $display("FAIL waw_done_cycle got ev=%b want 0", last_ev); end
      cycle();
      checks++;
      if (last_ev !== 1'b1 || exec_hs != 2)
         begin errors++; $display("FAIL waw_release got ev=%b hs=%0d want 1 2", last_ev, exec_hs); end
      bus.i_exec_done = 1; bus.i_exec_done_reg = 4'd3;
      cycle();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL scalar_idle got busy=%b want 0", busy); end
   endtask

   task automatic test_credits();
      do_reset();
      en = 1; bus.i_mem_ready = 1;
      for (int i = 0; i < 5; i++) push(mk(4'b0100, 4'(i)));
      repeat (14) cycle();
      checks++;
      if (mem_hs != 4 || last_mv !== 1'b0)
         begin errors++; $display("FAIL credit_limit got hs=%0d mv=%b want 4 0", mem_hs, last_mv); end
      bus.i_mem_done = 1; bus.i_mem_done_reg = 4'd0;
      cycle();
      cycle();
      checks++;
      if (last_mv !== 1'b1 || mem_hs != 5)
         begin errors++; $display("FAIL credit_release got mv=%b hs=%0d want 1 5", last_mv, mem_hs); end
      for (int i = 1; i < 5; i++) begin
         bus.i_mem_done = 1; bus.i_mem_done_reg = 4'(i);
         cycle();
      end
      checks++;
      if (busy !== 1'b0 || euf !== 1'b0)
         begin errors++; $display("FAIL credit_drain got busy=%b uf=%b want 0 0", busy, euf); end
   endtask

   task automatic test_store_fence();
      do_reset();
      en = 1; bus.i_mem_ready = 1;
      push(mk(4'b0100, 4'd1));
      push(mk(4'b0010, 4'd2));
      repeat (8) cycle();
      checks++;
      if (mem_hs != 1 || last_mv !== 1'b0)
         begin errors++; $display("FAIL fence_hold got hs=%0d mv=%b want 1 0", mem_hs, last_mv); end
      bus.i_mem_done = 1; bus.i_mem_done_reg = 4'd1;
      cycle();
      cycle();
      checks++;
      if (last_mv !== 1'b1 || mem_hs != 2)
         begin errors++; $display("FAIL fence_release got mv=%b hs=%0d want 1 2", last_mv, mem_hs); end
      bus.i_mem_done = 1; bus.i_mem_done_reg = 4'd2;
      cycle();
   endtask

   task automatic test_illegal();
      do_reset();
      en = 1; bus.i_exec_ready = 1; bus.i_mem_ready = 1;
      push(mk(4'b0110, 4'd6));
      push(mk(4'b0000, 4'd7));
      repeat (6) cycle();
      checks++;
      if (mem_hs != 0 || exec_hs != 1 || eill !== 1'b1)
         begin errors++; $display("FAIL illegal_drop got mem=%0d exec=%0d err=%b want 0 1 1",
            mem_hs, exec_hs, eill); end
      checks++;
      if (bus.o_op_instr[15:12] !== 4'd7)
         begin errors++; $display("FAIL illegal_next got dest=%0d want 7", bus.o_op_instr[15:12]); end
      bus.i_exec_done = 1; bus.i_exec_done_reg = 4'd7;
      cycle();
      checks++;
      if (eill !== 1'b1 || busy !== 1'b0)
         begin errors++; $display("FAIL illegal_sticky got err=%b busy=%b want 1 0", eill, busy); end
   endtask

   task automatic test_flush();
      int budget;
      do_reset();
      en = 1; bus.i_exec_ready = 1;
      push(mk(4'b0000, 4'd8));
      push(mk(4'b0001, 4'd9));
      budget = 10;
      while (exec_hs < 2 && budget > 0) begin cycle(); budget--; end
      checks++;
      if (exec_hs != 2) begin errors++; $display("FAIL flush_setup got hs=%0d want 2", exec_hs); end
      push(mk(4'b0000, 4'd10));
      flush = 1;
      cycle();
      repeat (3) cycle();
      checks++;
      if (deq_cnt != 2 || fd_cnt != 0 || busy !== 1'b1)
         begin errors++; $display("FAIL flush_nopop got deq=%0d fd=%0d busy=%b want 2 0 1",
            deq_cnt, fd_cnt, busy); end
      bus.i_exec_done = 1; bus.i_exec_done_reg = 4'd8;
      cycle();
      bus.i_exec_done = 1; bus.i_exec_done_reg = 4'd9;
      cycle();
      checks++;
      if (fd_cnt != 0) begin errors++; $display("FAIL flush_early got fd=%0d want 0", fd_cnt); end
      cycle();
      checks++;
      if (last_fd !== 1'b1 || fd_cnt != 1)
         begin errors++; $display("FAIL flush_done got fd=%b cnt=%0d want 1 1", last_fd, fd_cnt); end
      cycle();
      checks++;
      if (last_deq !== 1'b1) begin errors++; $display("FAIL flush_resume got deq=%b want 1", last_deq); end
`ifdef GPU_DISPATCH_STATS_EN
      checks++;
      if (se !== 32'd2) begin errors++; $display("FAIL flush_stat_exec got %0d want 2", se); end
`else
      checks++;
      if (se !== 32'd0) begin errors++; $display("FAIL flush_stat_exec got %0d want 0", se); end
`endif
   endtask

   task automatic test_underflow();
      do_reset();
      bus.i_mem_done = 1; bus.i_mem_done_reg = 4'd0;
      cycle();
      checks++;
      if (euf !== 1'b1 || busy !== 1'b0 || eill !== 1'b0)
         begin errors++; $display("FAIL underflow got uf=%b busy=%b ill=%b want 1 0 0",
            euf, busy, eill); end
   endtask

   task automatic test_async_reset();
      do_reset();
      en = 1;
      push(mk(4'b0000, 4'd4));
      cycle();
      cycle();
      rst = 1;
      #1;
      checks++;
      if (busy !== 1'b0 || bus.o_exec_valid !== 1'b0 || bus.o_op_instr !== '0)
         begin errors++; $display("FAIL async_reset got busy=%b ev=%b instr=%h want 0 0 0",
            busy, bus.o_exec_valid, bus.o_op_instr); end
      #1 rst = 0;
   endtask

   task automatic test_random();
      bit          m_hold, m_drain, m_eil, m_euf;
      logic [79:0] m_instr;
      logic [31:0] m_src, m_dst;
      int          cred_e, cred_m, st_e, st_m, st_s;
      bit          sb[16];
      int          out_e[$], out_m[$];
      bit          de, dm, hv, wm, rm, ill, to_mem, ok;
      bit          exp_deq, exp_ev, exp_mv, exp_fd, exp_busy, acc_e, acc_m;
      logic [3:0]  dest, dreg_e, dreg_m;
      logic [31:0] exp_se, exp_sm, exp_ss;
      int          idx, r;
      do_reset();
      m_hold = 0; m_drain = 0; m_eil = 0; m_euf = 0; m_instr = '0; m_src = '0; m_dst = '0;
      cred_e = 0; cred_m = 0; st_e = 0; st_m = 0; st_s = 0;
      foreach (sb[i]) sb[i] = 0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         if (pend.size() < 3 && $urandom_range(0, 3) != 0) begin
            r = $urandom_range(0, 9);
            if (r < 5)      push(mk({1'b0, 2'b00, 1'b0} | 4'($urandom_range(0, 1)) |
                                    (4'($urandom_range(0, 1)) << 3), 4'($urandom)));
            else if (r < 8) push(mk(4'b0100, 4'($urandom)));
            else if (r < 9) push(mk(4'b0010, 4'($urandom)));
            else            push(mk(4'b0110, 4'($urandom)));
         end
         en               = $urandom_range(0, 9) != 0;
         flush            = $urandom_range(0, 49) == 0;
         bus.i_exec_ready = $urandom_range(0, 2) != 0;
         bus.i_mem_ready  = $urandom_range(0, 2) != 0;
         de = out_e.size() > 0 && $urandom_range(0, 3) == 0;
         dm = out_m.size() > 0 && $urandom_range(0, 3) == 0;
         dreg_e = '0; dreg_m = '0;
         if (de) begin idx = $urandom_range(0, out_e.size() - 1); dreg_e = 4'(out_e[idx]);
            out_e.delete(idx); end
         if (dm) begin idx = $urandom_range(0, out_m.size() - 1); dreg_m = 4'(out_m[idx]);
            out_m.delete(idx); end
         bus.i_exec_done = de; bus.i_exec_done_reg = dreg_e;
         bus.i_mem_done  = dm; bus.i_mem_done_reg  = dreg_m;
         hv = pend.size() > 0;
         bus.i_dequeue_valid = hv;
         if (hv) begin
            bus.i_instruction = pend[0].instr; bus.i_src_addr = pend[0].src;
            bus.i_dst_addr = pend[0].dst;
         end
         #1;
         wm = m_instr[1]; rm = m_instr[2]; dest = m_instr[15:12];
         ill = wm && rm; to_mem = wm || rm;
         ok = m_hold && !ill && ((to_mem ? cred_m : cred_e) < MAXO) && !sb[dest] &&
              !(wm && cred_m != 0);
         exp_deq  = !m_hold && !m_drain && en && !flush && hv;
         exp_ev   = ok && !to_mem;
         exp_mv   = ok && to_mem;
         exp_fd   = m_drain && cred_e == 0 && cred_m == 0;
         exp_busy = m_hold || m_drain || cred_e != 0 || cred_m != 0;
`ifdef GPU_DISPATCH_STATS_EN
         exp_se = st_e; exp_sm = st_m; exp_ss = st_s;
`else
         exp_se = 0; exp_sm = 0; exp_ss = 0;
`endif
         checks++;
         if ({bus.o_dequeue_req, bus.o_exec_valid, bus.o_mem_valid} !== {exp_deq, exp_ev, exp_mv})
            begin errors++; $display("FAIL rand_ctrl cyc %0d got deq/ev/mv=%b want %b", cyc,
               {bus.o_dequeue_req, bus.o_exec_valid, bus.o_mem_valid}, {exp_deq, exp_ev, exp_mv});
            end
         checks++;
         if ({fdone, busy, eill, euf} !== {exp_fd, exp_busy, m_eil, m_euf})
            begin errors++; $display("FAIL rand_status cyc %0d got fd/busy/ill/uf=%b want %b", cyc,
               {fdone, busy, eill, euf}, {exp_fd, exp_busy, m_eil, m_euf}); end
         checks++;
         if ({se, sm, ss} !== {exp_se, exp_sm, exp_ss})
            begin errors++; $display("FAIL rand_stats cyc %0d got %0d %0d %0d want %0d %0d %0d",
               cyc, se, sm, ss, exp_se, exp_sm, exp_ss); end
         if (m_hold) begin
            checks++;
            if ({bus.o_op_instr, bus.o_op_src_addr, bus.o_op_dst_addr} !== {m_instr, m_src, m_dst})
               begin errors++; $display("FAIL rand_payload cyc %0d got %h want %h", cyc,
                  bus.o_op_instr, m_instr); end
         end
         // Advance the model by one cycle.
         acc_e = exp_ev && bus.i_exec_ready;
         acc_m = exp_mv && bus.i_mem_ready;
         if (m_hold && !acc_e && !acc_m) st_s++;
         if (de && cred_e == 0) m_euf = 1;
         if (dm && cred_m == 0) m_euf = 1;
         if (de && cred_e > 0) begin cred_e--; sb[dreg_e] = 0; end
         if (dm && cred_m > 0) begin cred_m--; sb[dreg_m] = 0; end
         if (acc_e) begin cred_e++; st_e++; sb[dest] = 1; out_e.push_back(int'(dest)); end
         if (acc_m) begin cred_m++; st_m++; sb[dest] = 1; out_m.push_back(int'(dest)); end
         if (m_drain) begin
            if (exp_fd) m_drain = 0;
         end else if (m_hold) begin
            if (ill) m_eil = 1;
            if (flush) begin m_hold = 0; m_drain = 1; end
            else if (ill || acc_e || acc_m) m_hold = 0;
         end else if (flush) begin
            m_drain = 1;
         end else if (exp_deq) begin
            m_hold = 1; m_instr = pend[0].instr; m_src = pend[0].src; m_dst = pend[0].dst;
            void'(pend.pop_front());
         end
         @(posedge clk);
         #1;
         flush = 0; bus.i_exec_done = 0; bus.i_mem_done = 0;
      end
   endtask

   initial begin
      test_reset();
      test_scalar_scoreboard();
      test_credits();
      test_store_fence();
      test_illegal();
      test_flush();
      test_underflow();
      test_async_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
